// File: rtl/bcd_cnt_pkg.sv
// ----------------------------------------------------------------------------
// bcd_cnt_pkg
// Shared constants and helpers for the cascaded BCD up/down counter.
//   DIGIT_W      : width of one BCD digit
//   BCD_MAX      : largest legal digit value
//   BCD_MIN      : smallest legal digit value
//   bcd_sanitize : maps an illegal nibble (10..15) to BCD_MIN
// ----------------------------------------------------------------------------
package bcd_cnt_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

    // Non-BCD nibbles load as zero so the counter never holds an illegal code.
    function automatic logic [DIGIT_W-1:0] bcd_sanitize(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MIN : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// ----------------------------------------------------------------------------
// bcd_digit
// One BCD digit of the up/down counter chain.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset, clears the digit to 0
//   adv   : counting edge for the whole chain (tick & enable, already gated)
//   up    : direction, 1 = increment, 0 = decrement
//   cin   : carry/borrow in; high when every lower digit is at its limit
//   load  : synchronous parallel load, overrides counting
//   data  : load value (illegal nibbles load as 0)
//   q     : current digit value
//   term  : terminal out; cin and this digit at its limit (9 up / 0 down)
// ----------------------------------------------------------------------------
module bcd_digit
    import bcd_cnt_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               adv,
    input  logic               up,
    input  logic               cin,
    input  logic               load,
    input  logic [DIGIT_W-1:0] data,
    output logic [DIGIT_W-1:0] q,
    output logic               term
);

    logic at_limit;

    assign at_limit = up ? (q == BCD_MAX) : (q == BCD_MIN);

    // Terminal ripples up the chain: a digit is "through" only if all
    // lower digits are also at their limit.
    assign term = cin & at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= bcd_sanitize(data);
        end else if (adv && cin) begin
            if (up) begin
                q <= at_limit ? BCD_MIN : q + 4'd1;
            end else begin
                q <= at_limit ? BCD_MAX : q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_cnt.sv
// ----------------------------------------------------------------------------
// bcd_updown_cnt
// Cascaded BCD up/down counter advanced by an internal clock-enable divider
// (no derived clocks; everything runs on CLK_50).
// Parameters:
//   DIGITS  : number of BCD digits (1..8)
//   DIV_LEN : tick period in CLK_50 cycles (1..2^26)
// Ports:
//   CLK_50 : system clock, rising edge
//   RST    : asynchronous active-high reset
//   EN     : count enable, only meaningful on tick cycles
//   UP     : direction, 1 = increment, 0 = decrement
//   LOAD   : synchronous parallel load, priority over counting, restarts divider
//   DATA   : BCD load value, digit 0 in [3:0]
//   DOUT   : registered BCD count, digit 0 in [3:0]
//   COUT   : combinational terminal count (all 9s up / all 0s down) & EN
//   TICK   : registered one-cycle divider strobe
// Build option:
//   BCD_SAT_EN : when defined, the counter saturates at all-9s / all-0s
//                instead of wrapping.
// ----------------------------------------------------------------------------
module bcd_updown_cnt
    import bcd_cnt_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIV_LEN = 50_000_000
) (
    input  logic                    CLK_50,
    input  logic                    RST,
    input  logic                    EN,
    input  logic                    UP,
    input  logic                    LOAD,
    input  logic [DIGIT_W*DIGITS-1:0] DATA,
    output logic [DIGIT_W*DIGITS-1:0] DOUT,
    output logic                    COUT,
    output logic                    TICK
);

`ifdef BCD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int DIV_W = (DIV_LEN > 1) ? $clog2(DIV_LEN) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_LEN - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIGITS:0]  chain;
    logic             all_term;
    logic             adv;

    // ------------------------------------------------------------------
    // Divider: counts 0..DIV_LEN-1; TICK is registered so it is high in
    // the cycle after the counter sits at DIV_LEN-1. A load restarts the
    // period so the next tick is a full DIV_LEN cycles away.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            div_cnt <= '0;
            TICK    <= 1'b0;
        end else if (LOAD) begin
            div_cnt <= '0;
            TICK    <= 1'b0;
        end else begin
            TICK    <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit chain. Digit 0 always has its carry/borrow-in asserted; the
    // terminal out of the top digit says the whole count is at its limit.
    // ------------------------------------------------------------------
    assign chain[0] = 1'b1;
    assign all_term = chain[DIGITS];

    // In saturating builds the limit simply blocks the advance.
    assign adv = TICK & EN & ~(SAT & all_term);

    assign COUT = EN & all_term;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk  (CLK_50),
            .rst  (RST),
            .adv  (adv),
            .up   (UP),
            .cin  (chain[i]),
            .load (LOAD),
            .data (DATA[DIGIT_W*i +: DIGIT_W]),
            .q    (DOUT[DIGIT_W*i +: DIGIT_W]),
            .term (chain[i+1])
        );
    end

endmodule

// File: tb/tb_bcd_updown_cnt.sv
// ----------------------------------------------------------------------------
// tb_bcd_updown_cnt
// Bench for bcd_updown_cnt with DIGITS=2, DIV_LEN=4. The reference model
// keeps the count as a plain integer 0..99 and the divider as a cycle count
// since the last restart. Each driven cycle pushes {DOUT, TICK, COUT}
// expected before the next edge; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_bcd_updown_cnt;

    localparam int DIGITS  = 2;
    localparam int DIV_LEN = 4;
    localparam int W       = 4*DIGITS + 2;

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [4*DIGITS-1:0]   dout;
    logic                  cout;
    logic                  tick;

    logic [W-1:0] exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_val  = 0;
    int m_cyc  = 0;
    bit m_tick = 1'b0;

    bcd_updown_cnt #(
        .DIGITS  (DIGITS),
        .DIV_LEN (DIV_LEN)
    ) dut (
        .CLK_50 (clk),
        .RST    (rst),
        .EN     (en),
        .UP     (up),
        .LOAD   (load),
        .DATA   (data),
        .DOUT   (dout),
        .COUT   (cout),
        .TICK   (tick)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        up   = 1'b1;
        load = 1'b0;
        data = '0;
    end

    // ---------------- model helpers ----------------
    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic int bcd_value(input logic [7:0] d);
        int hi;
        int lo;
        hi = int'(d[7:4]);
        lo = int'(d[3:0]);
        if (hi > 9) hi = 0;
        if (lo > 9) lo = 0;
        return hi*10 + lo;
    endfunction

    function automatic int step_val(input int v, input bit u);
`ifdef BCD_SAT_EN
        if (u) return (v == 99) ? 99 : v + 1;
        else   return (v == 0)  ? 0  : v - 1;
`else
        if (u) return (v + 1) % 100;
        else   return (v + 99) % 100;
`endif
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit r, input bit e, input bit u, input bit l,
                         input logic [7:0] d);
        bit was_rst;
        bit c_exp;
        @(posedge clk);
        #1;
        was_rst = rst;
        rst  = r;
        en   = e;
        up   = u;
        load = l;
        data = d;
        if (r) begin
            m_val  = 0;
            m_cyc  = 0;
            m_tick = 1'b0;
        end
        // asynchronous clear must be visible without any clock edge
        if (r && !was_rst) begin
            #1;
            check("async_rst_dout", dout, 8'h00);
            check("async_rst_tick", {7'd0, tick}, 8'h00);
        end
        c_exp = e & (u ? (m_val == 99) : (m_val == 0));
        exp_q.push_back({to_bcd(m_val), m_tick, c_exp});
        // model the upcoming edge
        if (!r) begin
            if (l) begin
                m_val  = bcd_value(d);
                m_cyc  = 0;
                m_tick = 1'b0;
            end else begin
                if (m_tick && e) m_val = step_val(m_val, u);
                m_cyc++;
                m_tick = (m_cyc % DIV_LEN == 0);
            end
        end
    endtask

    task automatic run(input int n, input bit e, input bit u);
        for (int i = 0; i < n; i++) drive(1'b0, e, u, 1'b0, 8'h00);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] ex;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            check("dout", dout, ex[W-1:2]);
            check("tick", {7'd0, tick}, {7'd0, ex[1]});
            check("cout", {7'd0, cout}, {7'd0, ex[0]});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit r;
        bit e;
        bit u;
        bit l;
        logic [7:0] d;
        logic [7:0] corner [4];
        int waited;

        corner[0] = 8'h99;
        corner[1] = 8'h00;
        corner[2] = 8'h98;
        corner[3] = 8'h01;

        // reset held; COUT follows EN & ~UP while in reset
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);

        // release: ticks after cycles 4, 8, 12, count held (EN=0)
        run(13, 1'b0, 1'b1);

        // 09 -> 10 upward, then 99 -> 00 wrap with COUT
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h09);
        run(6, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h99);
        run(6, 1'b1, 1'b1);

        // 10 -> 09 downward, then 00 -> 99 wrap with COUT
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h10);
        run(6, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        run(6, 1'b1, 1'b0);

        // illegal low nibble loads as 0, divider restarts
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h3A);
        run(6, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hC7);
        run(2, 1'b0, 1'b1);

        // hold across three ticks
        run(14, 1'b0, 1'b0);

        // async reset between ticks, then reset during a load
        run(5, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        run(3, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h42);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        run(9, 1'b1, 1'b0);

        // randomized traffic
        u = 1'b1;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            l = ($urandom_range(0, 14) == 0);
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) u = ~u;
            if ($urandom_range(0, 3) == 0) d = corner[$urandom_range(0, 3)];
            else                           d = 8'($urandom);
            drive(r, e, u, l, d);
        end

        // drain the scoreboard with a bounded wait
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
